// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory: wait states, byte-enabled stores,
// out-of-range and illegal-request detection, ready/done handshake.
module data_memory_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH = 10,
    parameter int WAIT_STATES = 1,
    parameter int SIGN_EXT = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = 16'h0111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   datain,
    input  logic [DATA_W/8-1:0] bytesel,
    input  logic                load,
    input  logic                store,
    output logic                ready,
    output logic [DATA_W-1:0]   dataout,
    output logic                done,
    output logic                err
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic [NB-1:0]     be_q;
    logic              ld_q;
    logic              st_q;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    logic [31:0]   uidx;
    logic [IW-1:0] widx;
    logic          neg;
    logic          in_rng;
    logic          acc;
    logic          we;

    always_comb begin
        uidx   = 32'(a_q);
        widx   = IW'(a_q);
        neg    = (SIGN_EXT != 0) && a_q[ADDR_W-1];
        in_rng = !neg && (uidx < 32'(DEPTH));
        acc    = (state == S_WAIT) && (cnt == 4'd0);
        we     = rst_n && acc && st_q && !ld_q && in_rng;
    end

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            dataout <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            a_q     <= '0;
            d_q     <= '0;
            be_q    <= '0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load || store) begin
                        a_q   <= address;
                        d_q   <= datain;
                        be_q  <= bytesel;
                        ld_q  <= load;
                        st_q  <= store;
                        cnt   <= 4'(WAIT_STATES);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (ld_q && st_q) begin
                            err <= 1'b1;
                        end else if (!in_rng) begin
                            err <= 1'b1;
                            if (ld_q) dataout <= '0;
                        end else begin
                            err <= 1'b0;
                            if (ld_q) dataout <= mem[widx];
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (be_q[k]) mem[widx][8*k +: 8] <= d_q[8*k +: 8];
            end
        end
    end

endmodule
